// File: rtl/wide_serializer_pkg.sv
// Shared types and elaboration helpers for the wide parallel-in/serial-out block.
package wide_serializer_pkg;

    localparam int unsigned SER_DATA_WIDTH = 32;

    // FIFO entry layout: order flag travels with its word.
    typedef struct packed {
        logic                      msb_first;
        logic [SER_DATA_WIDTH-1:0] data;
    } ser_entry_t;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } ser_state_e;

    function automatic int unsigned ser_beats(int unsigned dw, int unsigned lw);
        return dw / lw;
    endfunction

    function automatic int unsigned ser_cnt_width(int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic bit ser_widths_ok(int unsigned dw, int unsigned lw);
        return (lw != 0) && (lw <= dw) && ((dw % lw) == 0);
    endfunction

endpackage

// File: rtl/wide_serializer_if.sv
// Word input and beat output handshakes of wide_serializer.
interface wide_serializer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANE_WIDTH = 1
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  in_msb_first;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANE_WIDTH-1:0] lane_out;
    logic                  out_last;

    // master: word producer and beat consumer; slave: the serializer.
    modport master (
        output in_valid, data_in, in_msb_first, out_ready,
        input  in_ready, out_valid, lane_out, out_last
    );

    modport slave (
        input  in_valid, data_in, in_msb_first, out_ready,
        output in_ready, out_valid, lane_out, out_last
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy-based full/empty, flush and active-low reset.
module sync_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push && reset && !flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/wide_serializer.sv
// Buffered wide-word to LANE_WIDTH-beat serializer with per-word shift order.
module wide_serializer
    import wide_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANE_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    output logic              busy,
    wide_serializer_if.slave  bus
);

    localparam int unsigned   BEATS   = ser_beats(DATA_WIDTH, LANE_WIDTH);
    localparam int unsigned   CW      = ser_cnt_width(BEATS);
    localparam logic [CW-1:0] LastCnt = CW'(BEATS - 1);

    if (!ser_widths_ok(DATA_WIDTH, LANE_WIDTH)) begin : g_width_check
        $error("wide_serializer: DATA_WIDTH must be a multiple of LANE_WIDTH");
    end

    typedef struct packed {
        logic                  msb_first;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                push_entry;
    entry_t                head_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  load;

    ser_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  msb_q, msb_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LANE_WIDTH-1:0] lane_q, lane_d;
    logic                  last_q, last_d;

    assign push_entry = {bus.in_msb_first, bus.data_in};
    assign bus.in_ready = reset && !fifo_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (bus.in_valid && bus.in_ready),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        msb_d    = msb_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        load     = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = !fifo_empty;
            end
            StShift: begin
                if (bus.out_ready) begin
                    if (cnt_q != LastCnt) begin
                        shreg_d = msb_q ? (shreg_q << LANE_WIDTH) : (shreg_q >> LANE_WIDTH);
                        cnt_d   = cnt_q + 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            state_d  = StShift;
            shreg_d  = head_entry.data;
            msb_d    = head_entry.msb_first;
            cnt_d    = '0;
        end

        if (flush) begin
            fifo_pop = 1'b0;
            state_d  = StIdle;
            cnt_d    = '0;
        end

        // The lane register always reflects the beat at the active end of the next shift value.
        if (state_d == StShift) begin
            lane_d = msb_d ? shreg_d[DATA_WIDTH-1 -: LANE_WIDTH] : shreg_d[LANE_WIDTH-1:0];
        end else begin
            lane_d = '0;
        end
        last_d = (state_d == StShift) && (cnt_d == LastCnt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lane_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        msb_q   <= msb_d;
    end

    assign bus.out_valid = (state_q == StShift);
    assign bus.lane_out  = lane_q;
    assign bus.out_last  = last_q;
    assign busy          = !fifo_empty || (state_q == StShift);

endmodule
